// File: rtl/uart_tx_arb.sv
//
// uart_tx_arb
//    Two-requester byte arbiter feeding a single UART 8N1 transmitter.
//    Bytes are granted only while the transmitter is idle and the peer
//    holds cts low. A packet that has started (a byte accepted with
//    last==0) locks the arbiter to its requester until the byte carrying
//    last==1 is accepted. Unlocked ties alternate between the requesters.
//
// Parameters
//    CLK_DIV      clock cycles per UART bit (2..65535)
//
// Ports
//    clk          sole clock, rising edge
//    reset        synchronous, active-high reset
//    req0_data    byte offered by requester 0
//    req0_valid   requester 0 has a byte (data/last stable until accepted)
//    req0_last    offered byte ends requester 0's packet
//    req0_ready   one-cycle accept strobe for requester 0
//    req1_data    byte offered by requester 1
//    req1_valid   requester 1 has a byte (data/last stable until accepted)
//    req1_last    offered byte ends requester 1's packet
//    req1_ready   one-cycle accept strobe for requester 1
//    cts          synchronized clear-to-send, 0 = transmission permitted
//    tx           UART serial output, idle high
//    busy         high while a frame is being shifted out
//    owner        requester of the current or most recently accepted byte
//
module uart_tx_arb #(
   parameter int CLK_DIV = 104
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] req0_data,
   input  logic       req0_valid,
   input  logic       req0_last,
   output logic       req0_ready,
   input  logic [7:0] req1_data,
   input  logic       req1_valid,
   input  logic       req1_last,
   output logic       req1_ready,
   input  logic       cts,
   output logic       tx,
   output logic       busy,
   output logic       owner
);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   localparam logic [15:0] BIT_RELOAD = 16'(CLK_DIV - 1);

   state_t      state, state_n;
   logic [15:0] bit_cnt, bit_cnt_n;
   logic [2:0]  bit_idx, bit_idx_n;
   logic [7:0]  shift_reg, shift_n;
   logic        tx_q, tx_n;
   logic        owner_q, owner_n;
   logic        lock_on, lock_on_n;
   logic        lock_id, lock_id_n;
   logic        last_served, last_served_n;

   logic        elig0, elig1;
   logic        want0, want1;
   logic        grant_any;
   logic        grant_id;
   logic [7:0]  grant_data;
   logic        grant_last;

   // Arbitration. A held lock restricts eligibility to the locked
   // requester; otherwise a tie goes to whoever was not served last.
   // Grants are only possible in IDLE with cts low and reset released,
   // which also guarantees at most one ready per cycle.
   always_comb begin
      elig0      = !lock_on || (lock_id == 1'b0);
      elig1      = !lock_on || (lock_id == 1'b1);
      want0      = req0_valid && elig0;
      want1      = req1_valid && elig1;
      grant_any  = (state == IDLE) && !reset && !cts && (want0 || want1);
      grant_id   = (want0 && want1) ? ~last_served : want1;
      grant_data = grant_id ? req1_data : req0_data;
      grant_last = grant_id ? req1_last : req0_last;
      req0_ready = grant_any && !grant_id;
      req1_ready = grant_any &&  grant_id;
   end

   // Frame sequencer next-state logic. Each of START, DATA and STOP
   // counts bit_cnt down from CLK_DIV-1 to 0 per bit. tx is computed one
   // cycle ahead and registered so the line never glitches; the START bit
   // therefore appears the cycle after acceptance. In DATA the shift
   // register moves right at each bit boundary, so the next bit on the
   // line is always shift_reg[1] at that moment.
   always_comb begin
      state_n       = state;
      bit_cnt_n     = bit_cnt;
      bit_idx_n     = bit_idx;
      shift_n       = shift_reg;
      tx_n          = tx_q;
      owner_n       = owner_q;
      lock_on_n     = lock_on;
      lock_id_n     = lock_id;
      last_served_n = last_served;

      unique case (state)
         IDLE: begin
            tx_n = 1'b1;
            if (grant_any) begin
               state_n       = START;
               bit_cnt_n     = BIT_RELOAD;
               bit_idx_n     = 3'd0;
               shift_n       = grant_data;
               tx_n          = 1'b0;
               owner_n       = grant_id;
               last_served_n = grant_id;
               lock_on_n     = !grant_last;
               lock_id_n     = grant_id;
            end
         end
         START: begin
            if (bit_cnt == 16'd0) begin
               state_n   = DATA;
               bit_cnt_n = BIT_RELOAD;
               bit_idx_n = 3'd0;
               tx_n      = shift_reg[0];
            end else begin
               bit_cnt_n = bit_cnt - 16'd1;
            end
         end
         DATA: begin
            if (bit_cnt == 16'd0) begin
               bit_cnt_n = BIT_RELOAD;
               if (bit_idx == 3'd7) begin
                  state_n = STOP;
                  tx_n    = 1'b1;
               end else begin
                  bit_idx_n = bit_idx + 3'd1;
                  shift_n   = {1'b0, shift_reg[7:1]};
                  tx_n      = shift_reg[1];
               end
            end else begin
               bit_cnt_n = bit_cnt - 16'd1;
            end
         end
         STOP: begin
            tx_n = 1'b1;
            if (bit_cnt == 16'd0) begin
               state_n = IDLE;
            end else begin
               bit_cnt_n = bit_cnt - 16'd1;
            end
         end
         default: begin
            state_n = IDLE;
            tx_n    = 1'b1;
         end
      endcase
   end

   // State register. Reset aborts any frame in flight, drives the line
   // idle, drops the lock and marks requester 1 as last served so that
   // requester 0 wins the first tie after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         bit_cnt     <= 16'd0;
         bit_idx     <= 3'd0;
         shift_reg   <= 8'd0;
         tx_q        <= 1'b1;
         owner_q     <= 1'b0;
         lock_on     <= 1'b0;
         lock_id     <= 1'b0;
         last_served <= 1'b1;
      end else begin
         state       <= state_n;
         bit_cnt     <= bit_cnt_n;
         bit_idx     <= bit_idx_n;
         shift_reg   <= shift_n;
         tx_q        <= tx_n;
         owner_q     <= owner_n;
         lock_on     <= lock_on_n;
         lock_id     <= lock_id_n;
         last_served <= last_served_n;
      end
   end

   assign tx    = tx_q;
   assign busy  = (state != IDLE);
   assign owner = owner_q;

endmodule
